// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between the display host and seg_scan_ctrl.
// WR_EN and COMMIT are single-cycle strobes that are always accepted, so they have no ready.
interface seg_scan_ctrl_if;
  logic       ENABLE;
  logic       WR_EN;
  logic [2:0] WR_ADDR;
  logic [3:0] WR_DATA;
  logic       COMMIT;
  logic       LZ_SUPPRESS;
  logic       DEC_S1;
  logic [2:0] DEC_A;
  logic [3:0] BCD_A;
  logic       FRAME_DONE;
  logic       COMMIT_PEND;
  logic [1:0] STATE_DBG;

  modport master (
    output ENABLE, WR_EN, WR_ADDR, WR_DATA, COMMIT, LZ_SUPPRESS,
    input  DEC_S1, DEC_A, BCD_A, FRAME_DONE, COMMIT_PEND, STATE_DBG
  );

  modport slave (
    input  ENABLE, WR_EN, WR_ADDR, WR_DATA, COMMIT, LZ_SUPPRESS,
    output DEC_S1, DEC_A, BCD_A, FRAME_DONE, COMMIT_PEND, STATE_DBG
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display with
// double-buffered BCD digits, dwell/gap timing, zero suppression and frame-synchronous commit.
module seg_scan_ctrl #(
  parameter int N_DIGITS = 8,
  parameter int DWELL    = 1000,
  parameter int GAP      = 50
) (
  input  logic            CLK,
  input  logic            notRST,
  seg_scan_ctrl_if.slave  bus
);

  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam logic [2:0]    LAST_DIG   = 3'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [2:0]    digit, digit_n, digit_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    front [8];
  logic [3:0]    back  [8];
  logic [3:0]    front_n [8];
  logic          boundary, commit_req, copy, pend_n, fd_n, entering, lz_zero, blank_n;

  assign bus.STATE_DBG = state;
  assign digit_inc     = (digit == LAST_DIG) ? 3'd0 : digit + 3'd1;

  always_ff @(posedge CLK or negedge notRST) begin
    if (!notRST) begin
      state <= ST_IDLE;
      digit <= 3'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      digit <= digit_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    digit_n  = digit;
    cnt_n    = cnt + 1'b1;
    boundary = 1'b0;
    if (!bus.ENABLE) begin
      state_n = ST_IDLE;
      digit_n = 3'd0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_SHOW;
          digit_n = 3'd0;
          cnt_n   = '0;
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            cnt_n = '0;
            if (GAP > 0) begin
              state_n = ST_GAP;
            end else begin
              digit_n  = digit_inc;
              boundary = (digit == LAST_DIG);
            end
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state_n  = ST_SHOW;
            cnt_n    = '0;
            digit_n  = digit_inc;
            boundary = (digit == LAST_DIG);
          end
        end
        default: begin
          state_n = ST_IDLE;
          digit_n = 3'd0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // The copy samples back before this edge's write, so a same-cycle write stays in back only.
  always_comb begin
    commit_req = bus.COMMIT | bus.COMMIT_PEND;
    copy       = commit_req & ((state == ST_IDLE) | boundary);
    pend_n     = commit_req & ~copy;
    for (int i = 0; i < 8; i++) front_n[i] = copy ? back[i] : front[i];
    entering = (state_n == ST_SHOW) && (cnt_n == '0);
    lz_zero  = 1'b1;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j >= int'(digit_n) && front_n[j] != 4'd0) lz_zero = 1'b0;
    end
    blank_n = (front_n[digit_n] > 4'd9) ||
              (bus.LZ_SUPPRESS && digit_n != 3'd0 && lz_zero);
    fd_n = ((state_n == ST_GAP) && (digit_n == LAST_DIG) && (cnt_n == GAP_LAST)) ||
           ((GAP == 0) && (state_n == ST_SHOW) && (digit_n == LAST_DIG) &&
            (cnt_n == DWELL_LAST));
  end

  always_ff @(posedge CLK or negedge notRST) begin
    if (!notRST) begin
      for (int i = 0; i < 8; i++) begin
        front[i] <= 4'd0;
        back[i]  <= 4'd0;
      end
      bus.DEC_S1      <= 1'b0;
      bus.DEC_A       <= 3'd0;
      bus.BCD_A       <= 4'd0;
      bus.FRAME_DONE  <= 1'b0;
      bus.COMMIT_PEND <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) front[i] <= front_n[i];
      if (bus.WR_EN && ({1'b0, bus.WR_ADDR} < 4'(N_DIGITS))) back[bus.WR_ADDR] <= bus.WR_DATA;
      bus.COMMIT_PEND <= pend_n;
      bus.FRAME_DONE  <= fd_n;
      case (state_n)
        ST_SHOW: begin
          if (entering) begin
            bus.DEC_S1 <= ~blank_n;
            bus.DEC_A  <= digit_n;
            bus.BCD_A  <= front_n[digit_n];
          end
        end
        ST_GAP:  bus.DEC_S1 <= 1'b0;
        default: begin
          bus.DEC_S1 <= 1'b0;
          bus.DEC_A  <= 3'd0;
          bus.BCD_A  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Holds double-buffered BCD digit registers and cycles through the digits with a fixed dwell and an anti-ghosting gap.
- Drives the 3-8 digit-select decoder (S1 enable, 3-bit address) and the BCD-to-seven-segment decoder (4-bit code).
- Handles leading-zero suppression, invalid-code blanking and frame-synchronous commit of new display data.

Parameters:
N_DIGITS, 8, number of scanned digits, 1..8; digit N_DIGITS-1 is most significant.
DWELL, 1000, clock cycles each digit is lit, >=1.
GAP, 50, clock cycles all digits are dark between digits, >=0; 0 skips the gap.

Ports:
CLK  input  1  system clock, rising edge.
notRST  input  1  asynchronous active-low reset.
ENABLE  input  1  1 = scan runs; 0 = display dark, scanner idle.
WR_EN  input  1  write strobe into back buffer.
WR_ADDR  input  3  digit index for write.
WR_DATA  input  4  BCD value for write.
COMMIT  input  1  one-cycle request: copy back buffer to front buffer at next frame boundary.
LZ_SUPPRESS  input  1  1 = blank leading zeros.
DEC_S1  output  1  to 3-8 decoder S1; 0 = all digits off. Integrator ties notS2/notS3 low.
DEC_A  output  3  to 3-8 decoder A, current digit index.
BCD_A  output  4  to BCD-7seg decoder A, current digit value.
FRAME_DONE  output  1  one-cycle pulse at end of each full scan.
COMMIT_PEND  output  1  commit requested, not yet applied.

Behaviour:
- Reset (notRST=0, asynchronous): state IDLE, digit index 0, dwell/gap counter 0, front and back buffers all 0, DEC_S1=0, DEC_A=0, BCD_A=0, FRAME_DONE=0, COMMIT_PEND=0.
- All outputs are registered.
- Writes: WR_EN=1 writes WR_DATA into back[WR_ADDR] at the clock edge. WR_ADDR>=N_DIGITS is ignored. The front buffer is never written directly.
- States:
  - IDLE: DEC_S1=0, digit=0. With ENABLE=1, go to SHOW(digit 0) next cycle.
  - SHOW(d): lasts exactly DWELL cycles. DEC_A=d, BCD_A=front[d], DEC_S1 = not blank(d). Then GAP if GAP>0, else the next SHOW.
  - GAP(d): lasts exactly GAP cycles. DEC_S1=0; DEC_A and BCD_A hold.
- Sequencing: after digit d, go to d+1. After d=N_DIGITS-1, wrap to 0; this is the frame boundary.
- FRAME_DONE is 1 for the single cycle in which the last digit's final GAP cycle ends (final SHOW cycle if GAP=0).
- blank(d) is 1 if front[d]>9, or if LZ_SUPPRESS=1, d!=0 and front[j]==0 for all j from d up to N_DIGITS-1. Digit 0 is never zero-suppressed. It is evaluated at SHOW entry.
- Commit:
  - COMMIT=1 sets COMMIT_PEND.
  - At a frame boundary edge with COMMIT_PEND=1 (or COMMIT=1 that same cycle), front<=back and COMMIT_PEND clears. Digit 0 of the new frame shows the new data.
  - A write in the same cycle as the copy lands in back only; front receives the pre-write back value.
  - In IDLE, a pending commit applies on the next edge.
- ENABLE falls mid-frame: go to IDLE on the next edge, DEC_S1=0 that cycle, digit and counter reset, no FRAME_DONE. COMMIT_PEND is retained. Re-enable always restarts at digit 0.
- ENABLE is sampled every cycle. A one-cycle low pulse still forces IDLE.
- N_DIGITS=1: every SHOW/GAP completion is a frame boundary.
- Counters are sized to ceil(log2(max(DWELL,GAP)+1)). No overflow is possible.

Test Plan:
- Parameters N_DIGITS=4, DWELL=4, GAP=2 for all scenarios.
- Reset and idle: notRST pulse low mid-SHOW -> all outputs 0 immediately, not waiting for CLK. ENABLE=0 for 20 cycles -> DEC_S1 stays 0.
- Basic scan: write back={0:1,1:2,2:3,3:4}, COMMIT, ENABLE=1 -> DEC_A 0,1,2,3,0 each lit 4 cycles with 2 dark cycles between. BCD_A=1,2,3,4. FRAME_DONE every 24 cycles.
- Double buffer: mid-frame write back[0]=9 plus COMMIT -> current frame still shows 1 at digit 0. COMMIT_PEND=1 until the boundary, then digit 0 shows 9 and COMMIT_PEND=0.
- Blanking: front={0:5,1:0,2:0,3:0}, LZ_SUPPRESS=1 -> DEC_S1=1 only for digit 0. front[1]=12 with LZ_SUPPRESS=0 -> digit 1 dark, the other digits lit.
- Disable mid-frame: ENABLE low during SHOW(2) -> next cycle DEC_S1=0, no FRAME_DONE. ENABLE high -> restart at DEC_A=0.
- Edge cases: WR_ADDR=6 write ignored. COMMIT coincident with the FRAME_DONE cycle applies at that boundary. Write in the copy cycle is visible only after the following commit.
